// File: rtl/tape_write_ctrl_if.sv
// Bus bundle for the tape write controller: command input, video-out FIFO write port
// and the MAC-facing status reply stream.
interface tape_write_ctrl_if;
    logic        cmd_valid;
    logic [3:0]  cmd_op;
    logic [3:0]  cmd_arg;
    logic        fifo_wclk;
    logic        fifo_wreq;
    logic [3:0]  fifo_wdata;
    logic [10:0] fifo_used;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic        tx_ready;
    logic        busy;
    logic        done;

    // The environment side: command source, FIFO level and MAC back-pressure
    modport master (
        output cmd_valid, cmd_op, cmd_arg, fifo_used, tx_ready,
        input  fifo_wclk, fifo_wreq, fifo_wdata, tx_data, tx_valid, tx_last, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, fifo_used, tx_ready,
        output fifo_wclk, fifo_wreq, fifo_wdata, tx_data, tx_valid, tx_last, busy, done
    );
endinterface

// File: rtl/tape_write_ctrl.sv
// Tape write controller: streams DATA nibbles into the video-out FIFO while recording,
// drains on STOP, and answers STATUS with a 4-byte snapshot reply.
module tape_write_ctrl #(
    parameter int HIGH_WATER = 1984
) (
    input logic            clk,
    input logic            rst,
    tape_write_ctrl_if.slave bus
);

    localparam int          REPLY_LEN = 4;
    localparam logic [1:0]  LAST_IDX  = 2'(REPLY_LEN - 1);
    localparam logic [10:0] HW_LEVEL  = 11'(HIGH_WATER);

    localparam logic [3:0] OP_START  = 4'h1;
    localparam logic [3:0] OP_DATA   = 4'h2;
    localparam logic [3:0] OP_STOP   = 4'h3;
    localparam logic [3:0] OP_STATUS = 4'h4;
    localparam logic [3:0] OP_ABORT  = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        DRAIN  = 2'd2,
        REPLY  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    state_t      ret_q;
    logic [1:0]  byte_idx_q;
    logic [15:0] drop_cnt_q;
    logic [31:0] reply_q;
    logic        wreq_q;
    logic [3:0]  wdata_q;
    logic        done_q;

    logic        drop_evt;
    logic        wr_evt;
    logic        enter_reply;
    logic        clear_cnt;
    logic        drain_done;
    logic        tx_accept;

    // Next-state decode; each cycle carries at most one command
    always_comb begin
        state_d     = state_q;
        drop_evt    = 1'b0;
        wr_evt      = 1'b0;
        enter_reply = 1'b0;
        clear_cnt   = 1'b0;
        drain_done  = 1'b0;
        tx_accept   = (state_q == REPLY) && bus.tx_ready;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    case (bus.cmd_op)
                        OP_START: begin
                            state_d   = RECORD;
                            clear_cnt = 1'b1;
                        end
                        OP_STATUS: begin
                            state_d     = REPLY;
                            enter_reply = 1'b1;
                        end
                        OP_DATA, OP_STOP: drop_evt = 1'b1;
                        default: ;
                    endcase
                end
            end
            RECORD: begin
                if (bus.cmd_valid) begin
                    case (bus.cmd_op)
                        OP_DATA: begin
                            if (bus.fifo_used < HW_LEVEL) wr_evt = 1'b1;
                            else                          drop_evt = 1'b1;
                        end
                        OP_STOP:  state_d = DRAIN;
                        OP_ABORT: state_d = IDLE;
                        OP_STATUS: begin
                            state_d     = REPLY;
                            enter_reply = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            DRAIN: begin
                if (bus.cmd_valid && bus.cmd_op == OP_ABORT) begin
                    state_d = IDLE;
                end else begin
                    if (bus.cmd_valid && bus.cmd_op == OP_DATA) drop_evt = 1'b1;
                    if (bus.fifo_used == 11'd0) begin
                        state_d    = IDLE;
                        drain_done = 1'b1;
                    end
                end
            end
            REPLY: begin
                // Nothing, not even ABORT, may cut a reply short
                if (bus.cmd_valid) drop_evt = 1'b1;
                if (tx_accept && byte_idx_q == LAST_IDX) state_d = ret_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ret_q      <= IDLE;
            byte_idx_q <= 2'd0;
            drop_cnt_q <= 16'd0;
            reply_q    <= 32'd0;
            wreq_q     <= 1'b0;
            wdata_q    <= 4'd0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            wreq_q  <= wr_evt;
            done_q  <= drain_done;
            if (wr_evt) wdata_q <= bus.cmd_arg;

            if (clear_cnt)
                drop_cnt_q <= 16'd0;
            else if (drop_evt && drop_cnt_q != 16'hFFFF)
                drop_cnt_q <= drop_cnt_q + 16'd1;

            // Whole reply is frozen on entry so bytes stay stable under back-pressure
            if (enter_reply) begin
                ret_q      <= state_q;
                byte_idx_q <= 2'd0;
                reply_q    <= {6'b0, state_q, drop_cnt_q, bus.fifo_used[10:3]};
            end else if (tx_accept) begin
                byte_idx_q <= byte_idx_q + 2'd1;
            end
        end
    end

    always_comb begin
        bus.tx_data = 8'h00;
        case (byte_idx_q)
            2'd0: bus.tx_data = reply_q[31:24];
            2'd1: bus.tx_data = reply_q[23:16];
            2'd2: bus.tx_data = reply_q[15:8];
            2'd3: bus.tx_data = reply_q[7:0];
            default: bus.tx_data = 8'h00;
        endcase
        if (state_q != REPLY) bus.tx_data = 8'h00;
    end

    assign bus.tx_valid   = (state_q == REPLY);
    assign bus.tx_last    = (state_q == REPLY) && (byte_idx_q == LAST_IDX);
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
    assign bus.fifo_wreq  = wreq_q;
    assign bus.fifo_wdata = wdata_q;
    assign bus.fifo_wclk  = clk;

endmodule

// File: tb/tb_tape_write_ctrl.sv
// Directed bench for tape_write_ctrl: recording, high-water drops, drain, status
// replies with back-pressure, drop counter saturation and reset mid-reply.
module tb_tape_write_ctrl;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_START  = 4'h1;
    localparam logic [3:0] OP_DATA   = 4'h2;
    localparam logic [3:0] OP_STOP   = 4'h3;
    localparam logic [3:0] OP_STATUS = 4'h4;
    localparam logic [3:0] OP_ABORT  = 4'hF;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic wrSeen;

    logic       stallReady [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] stallData  [6] = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h05};
    logic       stallLast  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    tape_write_ctrl_if bus();

    tape_write_ctrl #(.HIGH_WATER(1984)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #4 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [3:0] arg);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_arg   = arg;
        step();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_NOP;
        bus.cmd_arg   = 4'h0;
    endtask

    // Drains a full reply with tx_ready held high, byte 0 already on the bus
    task automatic readReply(input string tag, input logic [31:0] expected);
        logic [7:0] expByte;
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expByte = expected[31 - 8*i -: 8];
            checkOutput($sformatf("%s_valid%0d", tag, i), 16'(bus.tx_valid), 16'd1);
            checkOutput($sformatf("%s_data%0d", tag, i), 16'(bus.tx_data), 16'(expByte));
            checkOutput($sformatf("%s_last%0d", tag, i), 16'(bus.tx_last), 16'(i == 3));
            step();
        end
        bus.tx_ready = 1'b0;
        checkOutput({tag, "_valid_after"}, 16'(bus.tx_valid), 16'd0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_NOP;
        bus.cmd_arg   = 4'h0;
        bus.fifo_used = 11'd0;
        bus.tx_ready  = 1'b0;
        step();
        step();
        checkOutput("rst_wreq",    16'(bus.fifo_wreq),  16'd0);
        checkOutput("rst_wdata",   16'(bus.fifo_wdata), 16'd0);
        checkOutput("rst_txvalid", 16'(bus.tx_valid),   16'd0);
        checkOutput("rst_txlast",  16'(bus.tx_last),    16'd0);
        checkOutput("rst_txdata",  16'(bus.tx_data),    16'd0);
        checkOutput("rst_busy",    16'(bus.busy),       16'd0);
        checkOutput("rst_done",    16'(bus.done),       16'd0);
        rst = 1'b0;

        // Two back-to-back writes, each one cycle after its command
        applyStimulus(OP_START, 4'h0);
        checkOutput("start_busy", 16'(bus.busy), 16'd1);
        checkOutput("start_wreq", 16'(bus.fifo_wreq), 16'd0);
        applyStimulus(OP_DATA, 4'hA);
        checkOutput("wr1_wreq",  16'(bus.fifo_wreq),  16'd1);
        checkOutput("wr1_wdata", 16'(bus.fifo_wdata), 16'hA);
        applyStimulus(OP_DATA, 4'h5);
        checkOutput("wr2_wreq",  16'(bus.fifo_wreq),  16'd1);
        checkOutput("wr2_wdata", 16'(bus.fifo_wdata), 16'h5);
        step();
        checkOutput("wr_idle_wreq", 16'(bus.fifo_wreq), 16'd0);

        // At the high-water mark every DATA is dropped and counted
        bus.fifo_used = 11'd1984;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(OP_DATA, 4'(i + 1));
            checkOutput($sformatf("hw_wreq%0d", i), 16'(bus.fifo_wreq), 16'd0);
        end
        applyStimulus(OP_STATUS, 4'h0);
        readReply("st_full", 32'h0100_03F8);
        checkOutput("st_full_busy", 16'(bus.busy), 16'd1);

        // STOP then drain as the FIFO empties
        bus.fifo_used = 11'd5;
        applyStimulus(OP_STOP, 4'h0);
        checkOutput("drain_busy0", 16'(bus.busy), 16'd1);
        checkOutput("drain_done0", 16'(bus.done), 16'd0);
        step();
        bus.fifo_used = 11'd2;
        step();
        checkOutput("drain_busy1", 16'(bus.busy), 16'd1);
        checkOutput("drain_done1", 16'(bus.done), 16'd0);
        bus.fifo_used = 11'd0;
        step();
        checkOutput("drain_busy_end", 16'(bus.busy), 16'd0);
        checkOutput("drain_done_pulse", 16'(bus.done), 16'd1);
        step();
        checkOutput("drain_done_clear", 16'(bus.done), 16'd0);

        // Saturate the drop counter: 65540 dropped DATA beats
        applyStimulus(OP_START, 4'h0);
        bus.fifo_used = 11'd1984;
        wrSeen        = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_DATA;
        bus.cmd_arg   = 4'h7;
        for (int i = 0; i < 65540; i++) begin
            step();
            wrSeen = wrSeen | bus.fifo_wreq;
        end
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_NOP;
        bus.cmd_arg   = 4'h0;
        checkOutput("sat_no_write", 16'(wrSeen), 16'd0);
        applyStimulus(OP_STATUS, 4'h0);
        readReply("st_sat", 32'h01FF_FFF8);

        // Reply from IDLE with MAC back-pressure
        applyStimulus(OP_ABORT, 4'h0);
        checkOutput("abort_busy", 16'(bus.busy), 16'd0);
        bus.fifo_used = 11'd40;
        applyStimulus(OP_STATUS, 4'h0);
        for (int i = 0; i < 6; i++) begin
            bus.tx_ready = stallReady[i];
            checkOutput($sformatf("stall_valid%0d", i), 16'(bus.tx_valid), 16'd1);
            checkOutput($sformatf("stall_data%0d", i),  16'(bus.tx_data),  16'(stallData[i]));
            checkOutput($sformatf("stall_last%0d", i),  16'(bus.tx_last),  16'(stallLast[i]));
            step();
        end
        bus.tx_ready = 1'b0;
        checkOutput("stall_valid_after", 16'(bus.tx_valid), 16'd0);
        checkOutput("stall_busy_after",  16'(bus.busy),     16'd0);

        // START clears the counter; ABORT during a reply is counted but harmless
        applyStimulus(OP_START, 4'h0);
        applyStimulus(OP_STATUS, 4'h0);
        applyStimulus(OP_ABORT, 4'h0);
        checkOutput("rep_abort_valid", 16'(bus.tx_valid), 16'd1);
        checkOutput("rep_abort_data",  16'(bus.tx_data),  16'h01);
        readReply("st_clr", 32'h0100_0005);
        checkOutput("st_clr_busy", 16'(bus.busy), 16'd1);

        // Reset while byte 2 is on the bus
        applyStimulus(OP_STATUS, 4'h0);
        bus.tx_ready = 1'b1;
        step();
        step();
        checkOutput("mid_data2", 16'(bus.tx_data), 16'h01);
        checkOutput("mid_last2", 16'(bus.tx_last), 16'd0);
        bus.tx_ready = 1'b0;
        rst = 1'b1;
        step();
        checkOutput("mid_rst_valid", 16'(bus.tx_valid), 16'd0);
        checkOutput("mid_rst_busy",  16'(bus.busy),     16'd0);
        checkOutput("mid_rst_data",  16'(bus.tx_data),  16'd0);
        rst = 1'b0;
        applyStimulus(OP_STATUS, 4'h0);
        readReply("st_after_rst", 32'h0000_0005);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tape_write_ctrl.md
TAPE_WRITE_CTRL -- requirements
Module: tape_write_ctrl

Interface
REQ-001 Parameter HIGH_WATER, default 1984, fifo_used level at or above which DATA beats are dropped.
REQ-002 Parameter REPLY_LEN, fixed 4, status reply length in bytes; not overridable.
REQ-003 clk  in  1  single clock, 125 MHz Ethernet clock; all logic on posedge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  parsed command beat present; upstream cannot stall.
REQ-006 cmd_op  in  4  command nibble: 0x0 NOP, 0x1 START, 0x2 DATA, 0x3 STOP, 0x4 STATUS, 0xF ABORT; others reserved.
REQ-007 cmd_arg  in  4  data nibble; payload for DATA, ignored otherwise.
REQ-008 fifo_wclk  out  1  FIFO write clock; driven directly from clk.
REQ-009 fifo_wreq  out  1  FIFO write request, one nibble per asserted cycle.
REQ-010 fifo_wdata  out  4  nibble written to video-out FIFO.
REQ-011 fifo_used  in  11  video-out FIFO used-words count.
REQ-012 tx_data  out  8  status reply byte.
REQ-013 tx_valid  out  1  tx_data valid.
REQ-014 tx_last  out  1  final reply byte marker, valid with tx_valid.
REQ-015 tx_ready  in  1  MAC accepts byte when tx_valid and tx_ready are both high.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 done  out  1  one-cycle pulse when a STOP drain completes.

Function
REQ-018 States: IDLE (code 0), RECORD (1), DRAIN (2), REPLY (3); state register binary, 2 bits.
REQ-019 IDLE: START -> RECORD; STATUS -> REPLY; DATA, STOP dropped; NOP, ABORT, reserved ignored.
REQ-020 RECORD: DATA with fifo_used < HIGH_WATER -> fifo_wreq=1, fifo_wdata=cmd_arg exactly one cycle later (registered, latency 1).
REQ-021 RECORD: DATA with fifo_used >= HIGH_WATER -> no write, drop_cnt increments.
REQ-022 RECORD: STOP -> DRAIN; ABORT -> IDLE; STATUS -> REPLY, returning to RECORD after reply; START ignored.
REQ-023 DRAIN: wait until fifo_used == 0, then pulse done for one cycle and enter IDLE on the same edge.
REQ-024 DRAIN: ABORT -> IDLE with no done pulse; DATA dropped and counted; other commands ignored.
REQ-025 A write pending from the last RECORD cycle still issues on the following cycle regardless of state change.
REQ-026 REPLY: tx_valid=1; bytes in order {6'b0,state_code_of_return_state}, drop_cnt[15:8], drop_cnt[7:0], fifo_used[10:3] sampled on REPLY entry.
REQ-027 REPLY: byte index advances only on tx_valid && tx_ready; tx_data stable while tx_ready low.
REQ-028 REPLY: tx_last=1 on byte 3; on its acceptance tx_valid drops next cycle and state returns to origin (IDLE or RECORD).
REQ-029 REPLY: every incoming command except ABORT is dropped and counted; ABORT is also dropped and counted, never truncating a reply.
REQ-030 drop_cnt: 16-bit, saturates at 0xFFFF, cleared only by reset or an accepted START.
REQ-031 A single cycle carries at most one command; cmd_valid low means no event.

Reset
REQ-032 On rst high at any clock edge, including mid-RECORD or mid-REPLY: state=IDLE, drop_cnt=0, byte index=0, pending write cleared.
REQ-033 Outputs during and after reset until first command: fifo_wreq=0, fifo_wdata=0, tx_valid=0, tx_last=0, tx_data=0, busy=0, done=0.

Verification
REQ-034 START, DATA 0xA, DATA 0x5, fifo_used=0 -> fifo_wreq high two consecutive cycles, wdata 0xA then 0x5, each one cycle after its command.
REQ-035 RECORD, fifo_used=1984, three DATA -> no fifo_wreq; subsequent STATUS reply bytes 0x01,0x00,0x03,0xF8.
REQ-036 RECORD, STOP, fifo_used 5 falling to 0 -> busy high until the edge after fifo_used==0, done one-cycle pulse, state IDLE.
REQ-037 IDLE, STATUS, tx_ready toggling 1,0,0,1,1,1 -> four bytes accepted, tx_data held while stalled, tx_last on 4th, tx_valid low after.
REQ-038 Saturation: 65540 DATA drops -> reply bytes 1-2 = 0xFF,0xFF; START then STATUS -> bytes 1-2 = 0x00,0x00.
REQ-039 rst asserted mid-REPLY on byte 2 -> next cycle tx_valid=0, busy=0; following STATUS restarts reply at byte 0.
